// File: rtl/conv_fifo_pkg.sv
// rtl/conv_fifo_pkg.sv - shared types and elaboration helpers for conv_fifo
package conv_fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } conv_fifo_status_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit levels_ok(input int depth, input int ae_level, input int af_level);
    return (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// rtl/fifo_ram_dp.sv - dual-port storage with one write port and a registered read port
// The array itself is never reset; only the read register is, so dout starts at zero.
module fifo_ram_dp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/conv_fifo.sv
// rtl/conv_fifo.sv - pointer, count and flag controller for the convolver FIFO
// Flags come only from registered pointers/count, so none depends combinationally on wr_en/rd_en.
module conv_fifo
  import conv_fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              din,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_valid,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [ptr_width(DEPTH):0]     count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = ptr_width(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("conv_fifo: DEPTH must be a power of two and at least 4");
  end
  if (!levels_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_levels
    $error("conv_fifo: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        dout_valid_q, dout_valid_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        push_ok, pop_ok;
  conv_fifo_status_t status;

  assign status.full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign status.empty        = (wr_ptr_q == rd_ptr_q);
  assign status.almost_full  = (count_q >= (AW+1)'(AF_LEVEL));
  assign status.almost_empty = (count_q <= (AW+1)'(AE_LEVEL));
  assign status.overflow     = overflow_q;
  assign status.underflow    = underflow_q;

  // Flush swallows both requests, so neither memory port fires that cycle.
  assign push_ok = wr_en && !status.full  && !flush;
  assign pop_ok  = rd_en && !status.empty && !flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_valid_d = pop_ok;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      dout_valid_d = 1'b0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_en && status.full)  overflow_d  = 1'b1;
      if (rd_en && status.empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  fifo_ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (din),
    .rd_en_i   (pop_ok),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (dout)
  );

  assign dout_valid   = dout_valid_q;
  assign count        = count_q;
  assign full         = status.full;
  assign almost_full  = status.almost_full;
  assign empty        = status.empty;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule

// File: tb/tb_conv_fifo.sv
// tb/tb_conv_fifo.sv - directed self-checking bench for conv_fifo (WIDTH=16, DEPTH=8)
module tb_conv_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wr_en;
  logic [15:0] din;
  logic        rd_en;
  logic [15:0] dout;
  logic        dout_valid;
  logic        full, almost_full, empty, almost_empty;
  logic [3:0]  count;
  logic        overflow, underflow;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  conv_fifo #(
    .WIDTH    (16),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    wr_en = 1'b1; rd_en = 1'b0; din = d;
    tick();
    idle();
  endtask

  task automatic pop();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".empty"}, empty, 1);
    chk({tag, ".aempty"}, almost_empty, 1);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".afull"}, almost_full, 0);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".dout"}, dout, 0);
    chk({tag, ".dvalid"}, dout_valid, 0);
    chk({tag, ".ovf"}, overflow, 0);
    chk({tag, ".unf"}, underflow, 0);
  endtask

  task automatic fill_drain();
    for (int i = 1; i <= 8; i++) begin
      push(16'(i));
      chk("fill.count", count, i);
      chk("fill.afull", almost_full, (i >= 6));
      chk("fill.full", full, (i == 8));
      chk("fill.ovf", overflow, 0);
    end
    push(16'h0009);
    chk("ovf.count", count, 8);
    chk("ovf.flag", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      chk("drain.dout", dout, i);
      chk("drain.dvalid", dout_valid, 1);
      chk("drain.count", count, 8 - i);
      chk("drain.aempty", almost_empty, ((8 - i) <= 2));
      chk("drain.empty", empty, (i == 8));
    end
    idle();
    tick();
    chk("drain.dvalid_drop", dout_valid, 0);
    chk("drain.dout_hold", dout, 16'h0008);
    chk("drain.ovf_sticky", overflow, 1);
    do_flush();
    chk("drain.ovf_clr", overflow, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    din = '0;

    for (int i = 0; i < 6; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      din   = 16'($urandom);
      tick();
      chk_reset_vals("rst");
    end
    idle();
    rst_n = 1'b1;
    tick();
    push(16'h00A1);
    chk("first.count", count, 1);
    chk("first.empty", empty, 0);
    pop();
    chk("first.dout", dout, 16'h00A1);
    chk("first.dvalid", dout_valid, 1);

    fill_drain();

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 5; j++) begin
        push(16'(16'h0100 + r * 5 + j));
        chk("wrap.count_up", count, j + 1);
      end
      for (int j = 0; j < 5; j++) begin
        pop();
        chk("wrap.dout", dout, 16'h0100 + r * 5 + j);
        chk("wrap.count_dn", count, 4 - j);
      end
    end

    for (int j = 0; j < 4; j++) push(16'(16'h0020 + j));
    wr_en = 1'b1; rd_en = 1'b1; din = 16'h0024;
    tick();
    idle();
    chk("sim4.count", count, 4);
    chk("sim4.dout", dout, 16'h0020);
    chk("sim4.dvalid", dout_valid, 1);
    do_flush();

    for (int j = 0; j < 8; j++) push(16'(16'h0030 + j));
    chk("simfull.full_pre", full, 1);
    wr_en = 1'b1; rd_en = 1'b1; din = 16'h0099;
    tick();
    idle();
    chk("simfull.count", count, 7);
    chk("simfull.ovf", overflow, 1);
    chk("simfull.dout", dout, 16'h0030);
    do_flush();

    wr_en = 1'b1; rd_en = 1'b1; din = 16'h0040;
    tick();
    idle();
    chk("simempty.count", count, 1);
    chk("simempty.unf", underflow, 1);
    chk("simempty.dvalid", dout_valid, 0);
    chk("simempty.dout_hold", dout, 16'h0030);

    for (int j = 1; j <= 5; j++) push(16'(16'h0050 + j));
    pop();
    chk("flushpre.count", count, 5);
    chk("flushpre.dout", dout, 16'h0040);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 16'h0077;
    tick();
    idle();
    chk("flush.count", count, 0);
    chk("flush.empty", empty, 1);
    chk("flush.ovf", overflow, 0);
    chk("flush.unf", underflow, 0);
    chk("flush.dout", dout, 16'h0040);
    chk("flush.dvalid", dout_valid, 0);
    push(16'h0BEE);
    pop();
    chk("flush.bee", dout, 16'h0BEE);
    chk("flush.bee_count", count, 0);

    push(16'h0070);
    push(16'h0071);
    pop();
    chk("arst.pre_dout", dout, 16'h0070);
    wr_en = 1'b1; din = 16'h0072;
    tick();
    chk("arst.pre_count", count, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    idle();
    tick();
    chk_reset_vals("arst_hold");
    rst_n = 1'b1;
    tick();
    fill_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary, expected completion");
    $fatal(1);
  end

endmodule
